// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data bits LSB-first, optional parity, 1 stop bit.
// The byte is held for the consumer behind a valid/read handshake with per-byte error flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       i_Clock,
  input  logic       rst,
  input  logic       eps,
  input  logic       pen,
  input  logic       i_Rx_Serial,
  input  logic       i_Rx_Read,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Valid,
  output logic       o_Rx_Busy,
  output logic       o_Parity_Err,
  output logic       o_Frame_Err,
  output logic       o_Overrun
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_C = CW'(HALF);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

  state_t        state, state_n;
  logic [1:0]    sync;
  logic          rxs;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          perr, perr_n;
  logic          pen_l, pen_n, eps_l, eps_n;
  logic [7:0]    byte_n;
  logic          valid_n, perr_o_n, ferr_n, ovr_n;
  logic          samp;

  assign rxs       = sync[1];
  assign samp      = (cnt == LAST);
  assign o_Rx_Busy = (state != IDLE);

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge i_Clock or negedge rst) begin
    if (!rst) sync <= 2'b11;
    else      sync <= {sync[0], i_Rx_Serial};
  end

  always_ff @(posedge i_Clock or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shift        <= '0;
      perr         <= 1'b0;
      pen_l        <= 1'b0;
      eps_l        <= 1'b0;
      o_Rx_Byte    <= '0;
      o_Rx_Valid   <= 1'b0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Overrun    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      shift        <= shift_n;
      perr         <= perr_n;
      pen_l        <= pen_n;
      eps_l        <= eps_n;
      o_Rx_Byte    <= byte_n;
      o_Rx_Valid   <= valid_n;
      o_Parity_Err <= perr_o_n;
      o_Frame_Err  <= ferr_n;
      o_Overrun    <= ovr_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shift_n  = shift;
    perr_n   = perr;
    pen_n    = pen_l;
    eps_n    = eps_l;
    byte_n   = o_Rx_Byte;
    valid_n  = o_Rx_Valid;
    perr_o_n = o_Parity_Err;
    ferr_n   = o_Frame_Err;
    ovr_n    = o_Overrun;

    if (i_Rx_Read) begin
      valid_n = 1'b0;
      ovr_n   = 1'b0;
    end

    case (state)
      IDLE: begin
        if (!rxs) begin
          if (HALF == 0) begin
            pen_n   = pen;
            eps_n   = eps;
            cnt_n   = '0;
            idx_n   = '0;
            perr_n  = 1'b0;
            state_n = DATA;
          end else begin
            cnt_n   = CW'(1);
            state_n = START;
          end
        end
      end
      START: begin
        if (cnt == HALF_C) begin
          if (!rxs) begin
            pen_n   = pen;
            eps_n   = eps;
            cnt_n   = '0;
            idx_n   = '0;
            perr_n  = 1'b0;
            state_n = DATA;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (samp) begin
          cnt_n          = '0;
          shift_n[idx]   = rxs;
          idx_n          = idx + 3'd1;
          if (idx == 3'd7) state_n = pen_l ? PARITY : STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      PARITY: begin
        if (samp) begin
          cnt_n   = '0;
          perr_n  = rxs ^ ((^shift) ^ ~eps_l);
          state_n = STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (samp) begin
          cnt_n    = '0;
          byte_n   = shift;
          perr_o_n = perr;
          ferr_n   = ~rxs;
          valid_n  = 1'b1;
          // A coincident read consumes the old byte, so no overrun.
          if (o_Rx_Valid && !i_Rx_Read) ovr_n = 1'b1;
          state_n  = rxs ? IDLE : BREAK_WAIT;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      BREAK_WAIT: begin
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed checks of uart_rx at 1 and 16 clocks per bit.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst, eps, pen;
  logic rx1, rd1, rx16, rd16;
  logic [7:0] b1, b16;
  logic v1, bz1, pe1, fe1, ov1;
  logic v16, bz16, pe16, fe16, ov16;
  int total = 0;
  int bad = 0;
  logic mv, mo;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(1)) u1 (
    .i_Clock(clk), .rst(rst), .eps(eps), .pen(pen), .i_Rx_Serial(rx1), .i_Rx_Read(rd1),
    .o_Rx_Byte(b1), .o_Rx_Valid(v1), .o_Rx_Busy(bz1), .o_Parity_Err(pe1),
    .o_Frame_Err(fe1), .o_Overrun(ov1));

  uart_rx #(.CLKS_PER_BIT(16)) u16 (
    .i_Clock(clk), .rst(rst), .eps(eps), .pen(pen), .i_Rx_Serial(rx16), .i_Rx_Read(rd16),
    .o_Rx_Byte(b16), .o_Rx_Valid(v16), .o_Rx_Busy(bz16), .o_Parity_Err(pe16),
    .o_Frame_Err(fe16), .o_Overrun(ov16));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Parity bit the transmitter would send: even total ones when eps=1, odd when eps=0.
  function automatic logic good_par(input logic [7:0] d, input logic ep);
    logic odd;
    odd = ($countones(d) % 2) == 1;
    return ep ? odd : !odd;
  endfunction

  task automatic send1(input logic [7:0] d, input logic pe, input logic ep,
                       input logic pbit, input logic sbit, input bit scr);
    pen = pe; eps = ep;
    rx1 = 1'b0; tick;
    for (int i = 0; i < 8; i++) begin
      rx1 = d[i]; tick;
      if (scr && i == 1) begin pen = 1'($urandom); eps = 1'($urandom); end
    end
    if (pe) begin rx1 = pbit; tick; end
    rx1 = sbit; tick;
    rx1 = 1'b1;
  endtask

  task automatic pulse_read1;
    rd1 = 1'b1; tick; rd1 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; eps = 0; pen = 0; rx1 = 1; rd1 = 0; rx16 = 1; rd16 = 0;
    #1;
    total++;
    if ({b1, v1, bz1, pe1, fe1, ov1} !== 13'h0) begin
      bad++; $display("FAIL reset_u1 got=%h want=0", {b1, v1, bz1, pe1, fe1, ov1});
    end
    total++;
    if ({b16, v16, bz16, pe16, fe16, ov16} !== 13'h0) begin
      bad++; $display("FAIL reset_u16 got=%h want=0", {b16, v16, bz16, pe16, fe16, ov16});
    end
    tick; tick; rst = 1'b1; tick; tick;
  endtask

  task automatic test_basic;
    send1(8'h4A, 0, 0, 0, 1, 0);
    tick;
    total++;
    if (v1 !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", v1); end
    tick;
    total++;
    if ({b1, v1, pe1, fe1} !== {8'h4A, 3'b100}) begin
      bad++; $display("FAIL basic_frame got=%h/%b%b%b want=4a/100", b1, v1, pe1, fe1);
    end
    pulse_read1;
    total++;
    if (v1 !== 1'b0) begin bad++; $display("FAIL basic_read got=%b want=0", v1); end
  endtask

  task automatic test_parity;
    logic [7:0] d [3] = '{8'hAE, 8'hAE, 8'hFF};
    logic       ep[3] = '{1'b0, 1'b0, 1'b1};
    logic       pb[3] = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      send1(d[k], 1, ep[k], pb[k], 1, 0);
      tick; tick;
      total++;
      if ({b1, v1, pe1, fe1} !== {d[k], 1'b1, pb[k] != good_par(d[k], ep[k]), 1'b0}) begin
        bad++; $display("FAIL parity_%0d got=%h/%b%b%b", k, b1, v1, pe1, fe1);
      end
      pulse_read1;
    end
  endtask

  task automatic test_frame_err;
    send1(8'h55, 0, 0, 0, 0, 0);
    rx1 = 1'b0;
    tick; tick;
    total++;
    if ({b1, v1, pe1, fe1, bz1} !== {8'h55, 4'b1011}) begin
      bad++; $display("FAIL frame_err got=%h/%b%b%b%b want=55/1011", b1, v1, pe1, fe1, bz1);
    end
    pulse_read1;
    tick; tick;
    total++;
    if ({bz1, v1} !== 2'b10) begin
      bad++; $display("FAIL break_wait got=%b%b want=10", bz1, v1);
    end
    rx1 = 1'b1;
    tick; tick; tick;
    total++;
    if (bz1 !== 1'b0) begin bad++; $display("FAIL break_exit got=%b want=0", bz1); end
    repeat (20) tick;
    total++;
    if (v1 !== 1'b0) begin bad++; $display("FAIL break_spurious got=%b want=0", v1); end
  endtask

  task automatic test_back_to_back;
    send1(8'h12, 0, 0, 0, 1, 0);
    send1(8'h34, 0, 0, 0, 1, 0);
    tick; tick;
    total++;
    if ({b1, v1, ov1} !== {8'h34, 2'b11}) begin
      bad++; $display("FAIL overrun got=%h/%b%b want=34/11", b1, v1, ov1);
    end
    pulse_read1;
    total++;
    if ({v1, ov1} !== 2'b00) begin
      bad++; $display("FAIL overrun_clear got=%b%b want=00", v1, ov1);
    end
    send1(8'h12, 0, 0, 0, 1, 0);
    send1(8'h34, 0, 0, 0, 1, 0);
    tick;
    rd1 = 1'b1; tick; rd1 = 1'b0;
    total++;
    if ({b1, v1, ov1} !== {8'h34, 2'b10}) begin
      bad++; $display("FAIL collision got=%h/%b%b want=34/10", b1, v1, ov1);
    end
    pulse_read1;
  endtask

  task automatic test_oversample;
    logic [9:0] fr;
    pen = 0; eps = 0;
    rx16 = 1'b0; repeat (3) tick;
    rx16 = 1'b1;
    total++;
    if (bz16 !== 1'b1) begin bad++; $display("FAIL os_start_seen got=%b want=1", bz16); end
    repeat (30) tick;
    total++;
    if ({v16, bz16} !== 2'b00) begin
      bad++; $display("FAIL os_glitch got=%b%b want=00", v16, bz16);
    end
    fr = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 10; i++) begin rx16 = fr[i]; repeat (16) tick; end
    rx16 = 1'b1;
    tick;
    total++;
    if ({b16, v16, pe16, fe16} !== {8'hC3, 3'b100}) begin
      bad++; $display("FAIL os_frame got=%h/%b%b%b want=c3/100", b16, v16, pe16, fe16);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    send1(8'hE7, 1, 0, ~good_par(8'hE7, 0), 1, 0);
    tick; tick;
    d = 8'h5A;
    rx1 = 1'b0; tick;
    for (int i = 0; i < 4; i++) begin rx1 = d[i]; tick; end
    rx1 = d[4];
    #2 rst = 1'b0;
    #1;
    total++;
    if ({b1, v1, bz1, pe1, fe1, ov1} !== 13'h0) begin
      bad++; $display("FAIL reset_mid_u1 got=%h want=0", {b1, v1, bz1, pe1, fe1, ov1});
    end
    total++;
    if ({b16, v16} !== 9'h0) begin
      bad++; $display("FAIL reset_mid_u16 got=%h want=0", {b16, v16});
    end
    rx1 = 1'b1;
    tick; tick;
    rst = 1'b1;
    tick; tick;
    send1(8'h81, 0, 0, 0, 1, 0);
    tick; tick;
    total++;
    if ({b1, v1, pe1, fe1, ov1} !== {8'h81, 4'b1000}) begin
      bad++; $display("FAIL reset_recover got=%h/%b%b%b%b want=81/1000", b1, v1, pe1, fe1, ov1);
    end
    pulse_read1;
  endtask

  task automatic test_random;
    logic [7:0] d;
    logic pe, ep, flip, sb, pb;
    mv = 1'b0; mo = 1'b0;
    for (int n = 0; n < 40; n++) begin
      d    = 8'($urandom);
      pe   = 1'($urandom);
      ep   = 1'($urandom);
      flip = ($urandom % 4) == 0;
      sb   = ($urandom % 5) != 0;
      if ($urandom % 2 == 1) begin pulse_read1; mv = 1'b0; mo = 1'b0; end
      repeat ($urandom_range(0, 2)) tick;
      pb = good_par(d, ep) ^ flip;
      send1(d, pe, ep, pb, sb, 1);
      tick; tick;
      if (mv) mo = 1'b1;
      mv = 1'b1;
      total++;
      if ({b1, v1, pe1, fe1, ov1} !== {d, mv, pe & flip, ~sb, mo}) begin
        bad++;
        $display("FAIL random_%0d got=%h/%b%b%b%b want=%h/%b%b%b%b", n, b1, v1, pe1, fe1, ov1,
                 d, mv, pe & flip, ~sb, mo);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_frame_err;
    test_back_to_back;
    test_oversample;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
